uart_tx_frame: RTL and testbench

//  Parametrised serial frame transmitter; next generation of the fixed 8-bit sender.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_tx_frame.sv | 144 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART frame transmitter.
// Contents:
//   state_e     transmitter FSM states
//   LINE_IDLE   idle (mark) level of the serial line
//   frame_bits  number of serial bits in one frame
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic LINE_IDLE = 1'b1;

    // Start bit + payload + optional parity + stop bits.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned stop_bits,
                                               input int unsigned p);
        return 1 + data_bits + p + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   run       count enable; the counter is held at 0 while low
//   bit_tick  high during the last clk cycle of each serial bit
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic bit_tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART frame transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity bit, STOP_BITS stop bits.
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the data
// (parity = ^data ^ PARITY_ODD). Without it PARITY_ODD has no effect.
// Ports:
//   clk      system clock
//   rst_n    synchronous active-low reset
//   en       data valid; word accepted when en && ready at a clk edge
//   data     payload, sampled only on acceptance
//   ready    idle and able to accept a word
//   busy     frame on the line
//   tx       serial output, idles high
//   tx_done  one-cycle pulse as the transmitter returns to idle
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 50,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx,
    output logic                 tx_done
);

    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_e               state;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state != IDLE),
        .bit_tick(bit_tick)
    );

    // tx always carries the bit of the current state; it is loaded on the
    // edge that enters the state so each bit lasts one full baud period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx      <= LINE_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state   <= START;
                        shreg   <= data;
                        bit_cnt <= '0;
                        tx      <= 1'b0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        par     <= (^data) ^ (PARITY_ODD != 0);
`endif
                    end else begin
                        tx    <= LINE_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            tx      <= par;
`else
                            state   <= STOP;
                            tx      <= LINE_IDLE;
`endif
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state   <= STOP;
                        tx      <= LINE_IDLE;
                        bit_cnt <= '0;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            tx      <= LINE_IDLE;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                            tx_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= LINE_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: two instances (8 data/1 stop, even
// parity and 5 data/2 stop, odd parity), directed frames plus randomized ones,
// compared cycle by cycle against a frame-level reference model.
module tb_uart_tx_frame;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en0, en1;
    logic [7:0] data0;
    logic [4:0] data1;
    logic       ready0, busy0, tx0, done0;
    logic       ready1, busy1, tx1, done1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .STOP_BITS   (1),
        .PARITY_ODD  (0)
    ) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en0),
        .data   (data0),
        .ready  (ready0),
        .busy   (busy0),
        .tx     (tx0),
        .tx_done(done0)
    );

    uart_tx_frame #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (5),
        .STOP_BITS   (2),
        .PARITY_ODD  (1)
    ) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en1),
        .data   (data1),
        .ready  (ready1),
        .busy   (busy1),
        .tx     (tx1),
        .tx_done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dbits(input int u);
        return (u == 0) ? 8 : 5;
    endfunction

    function automatic int sbits(input int u);
        return (u == 0) ? 1 : 2;
    endfunction

    // Expected line level for serial bit index idx of a frame carrying d.
    function automatic logic exp_bit(input int u, input logic [15:0] d, input int idx);
        int   db = dbits(u);
        logic p  = (u == 0) ? 1'b0 : 1'b1;
        for (int i = 0; i < db; i++) p ^= d[i];
        if (idx == 0) return 1'b0;
        if (idx <= db) return d[idx-1];
        if (P == 1 && idx == db + 1) return p;
        return 1'b1;
    endfunction

    function automatic logic [3:0] outs(input int u);
        // {tx, ready, busy, tx_done}
        return (u == 0) ? {tx0, ready0, busy0, done0} : {tx1, ready1, busy1, done1};
    endfunction

    task automatic drive(input int u, input logic e, input logic [15:0] d);
        if (u == 0) begin
            en0 = e;
            data0 = d[7:0];
        end else begin
            en1 = e;
            data1 = d[4:0];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle0", {28'd0, outs(0)}, 32'hC);
            check("idle1", {28'd0, outs(1)}, 32'hC);
        end
    endtask

    // Called at a negedge with en already driven for instance u; the accept
    // happens on the following edge k. mode: 0 quiet, 1 single en poke at k+10
    // with data 0x3C, 2 random en/data noise while busy. rst_at > 0 pulses
    // reset at edge k+rst_at and aborts the frame.
    task automatic frame(input int u, input logic [15:0] d, input bit b2b,
                         input logic [15:0] nd, input int rst_at, input int mode);
        int f = CPB * (1 + dbits(u) + P + sbits(u));
        logic [3:0] o;
        check($sformatf("ready_acc u%0d", u), {31'd0, outs(u)[2]}, 32'd1);
        for (int c = 1; c <= f + 1; c++) begin
            @(negedge clk);
            o = outs(u);
            if (rst_at > 0 && c == rst_at + 1) begin
                check($sformatf("after_rst u%0d", u), {28'd0, o}, 32'hC);
                rst_n = 1'b1;
                drive(u, 1'b0, 16'h0);
                return;
            end
            if (c <= f) begin
                check($sformatf("tx u%0d c%0d", u, c), {31'd0, o[3]},
                      {31'd0, exp_bit(u, d, (c - 1) / CPB)});
                check($sformatf("busy_flags u%0d c%0d", u, c), {29'd0, o[2:0]}, 32'h2);
            end else begin
                check($sformatf("done u%0d", u), {28'd0, o}, 32'hD);
            end
            if (c == f + 1) begin
                drive(u, b2b, nd);
            end else if (rst_at > 0 && c == rst_at) begin
                rst_n = 1'b0;
            end else if (mode == 1) begin
                drive(u, c == 10, (c == 10) ? 16'h003C : d);
            end else if (mode == 2) begin
                drive(u, 1'($urandom_range(0, 1)), 16'($urandom));
            end
        end
    endtask

    initial begin
        int          u;
        bit          chained;
        bit          b2b;
        logic [15:0] d, nd;

        rst_n = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        data0 = '0;
        data1 = '0;
        repeat (3) @(negedge clk);
        check("rst0", {28'd0, outs(0)}, 32'hC);
        check("rst1", {28'd0, outs(1)}, 32'hC);
        rst_n = 1'b1;
        idle(2);

        // Basic frame and parity-sensitive frame.
        drive(0, 1'b1, 16'h00A5);
        frame(0, 16'h00A5, 1'b0, 16'h0, 0, 0);
        idle(2);
        drive(0, 1'b1, 16'h0007);
        frame(0, 16'h0007, 1'b0, 16'h0, 0, 0);
        idle(2);

        // en held high: back-to-back frames.
        drive(0, 1'b1, 16'h0000);
        frame(0, 16'h0000, 1'b1, 16'h00FF, 0, 0);
        frame(0, 16'h00FF, 1'b0, 16'h0, 0, 0);
        idle(2);

        // en poke while busy is ignored.
        drive(0, 1'b1, 16'h00C3);
        frame(0, 16'h00C3, 1'b0, 16'h0, 0, 1);
        idle(2);

        // Reset mid-frame, then a clean frame accepted at k+20.
        drive(0, 1'b1, 16'h0096);
        frame(0, 16'h0096, 1'b0, 16'h0, 17, 0);
        idle(2);
        drive(0, 1'b1, 16'h0069);
        frame(0, 16'h0069, 1'b0, 16'h0, 0, 0);
        idle(2);

        // Five data bits, two stop bits.
        drive(1, 1'b1, 16'h0015);
        frame(1, 16'h0015, 1'b0, 16'h0, 0, 0);
        idle(2);

        // Randomized frames with gaps, chaining and bus noise.
        chained = 1'b0;
        u = 0;
        d = '0;
        for (int i = 0; i < 24; i++) begin
            if (!chained) begin
                u = $urandom_range(0, 1);
                d = 16'($urandom);
                idle($urandom_range(0, 3));
                drive(u, 1'b1, d);
            end
            b2b = (i < 23) && ($urandom_range(0, 2) == 0);
            nd = 16'($urandom);
            frame(u, d, b2b, nd, 0, 2);
            chained = b2b;
            d = nd;
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
